// File: rtl/perceptron_train_scheduler.sv
// perceptron_train_scheduler: issues training samples epoch by epoch, tracks errors/epochs,
// and lends the datapath to inference whenever no training run is active.
module perceptron_train_scheduler #(
  parameter int NUM = 4,
  parameter int EPOCH_W = 8,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EPOCH_W-1:0] max_epochs,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               sample_valid,
  input  logic               sample_ready,
  input  logic               result_valid,
  input  logic               result_error,
  input  logic               infer_req,
  output logic               infer_grant,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [IDX_W:0]     error_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EPOCH_END, DONE} state_t;
  state_t state, state_n;
  logic [EPOCH_W-1:0] limit;
  logic [EPOCH_W-1:0] epoch_inc;
  logic idle_like, last, epoch_stop;
  assign idle_like  = state == IDLE || state == DONE;
  assign last       = sample_idx == IDX_W'(NUM - 1);
  assign epoch_inc  = &epoch_count ? epoch_count : epoch_count + 1'b1;
  assign epoch_stop = error_count == '0 || epoch_inc == limit;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n      = state;
    sample_valid = state == ISSUE;
    busy         = state == ISSUE || state == WAIT || state == EPOCH_END;
    // Training wins the datapath: a start in the same cycle revokes the grant.
    infer_grant  = infer_req && idle_like && !start && !rst;
    case (state)
      IDLE, DONE: if (start) state_n = ISSUE;
      ISSUE:      if (sample_ready) state_n = WAIT;
      WAIT:       if (result_valid) state_n = last ? EPOCH_END : ISSUE;
      EPOCH_END:  state_n = epoch_stop ? DONE : ISSUE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sample_idx  <= '0;
      epoch_count <= '0;
      error_count <= '0;
      limit       <= '0;
      done        <= 1'b0;
      converged   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          sample_idx  <= '0;
          epoch_count <= '0;
          error_count <= '0;
          done        <= 1'b0;
          converged   <= 1'b0;
          limit       <= max_epochs == '0 ? EPOCH_W'(1) : max_epochs;
        end
        WAIT: if (result_valid) begin
          error_count <= error_count + {{IDX_W{1'b0}}, result_error};
          if (!last) sample_idx <= sample_idx + 1'b1;
        end
        EPOCH_END: begin
          epoch_count <= epoch_inc;
          if (epoch_stop) begin
            done      <= 1'b1;
            converged <= error_count == '0;
          end else begin
            sample_idx  <= '0;
            error_count <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule
